// File: rtl/tinker_fetch_if.sv
// Fetch unit bus bundle: instruction-memory request/response channel,
// decode-side instruction channel, and the redirect/halt controls.
interface tinker_fetch_if;
  // Instruction memory request channel
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  // Instruction memory response channel (in request order)
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  // Decode channel
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] instruction;
  logic [63:0] inst_pc;
  // Control from the core
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        halt;

  // The fetch unit itself
  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, instruction, inst_pc,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
           redirect_valid, redirect_pc, halt
  );

  // Memory, decode and core side
  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, instruction, inst_pc,
    output imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
           redirect_valid, redirect_pc, halt
  );
endinterface

// File: rtl/tinker_fetch_unit.sv
// Tinker instruction fetch stage. Issues sequential word reads, keeps the
// PC of every outstanding read in an in-order tag FIFO, buffers returned
// words in a small instruction queue, and hands them to decode one per
// cycle. A redirect flushes the queue and arms a drop counter so that
// responses to requests issued before the redirect are thrown away.
module tinker_fetch_unit #(
  parameter logic [63:0] RESET_PC    = 64'h2000,
  parameter int          QUEUE_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  tinker_fetch_if.master  bus
);

  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [CW-1:0] CNT_ONE = 1;

  // Architectural state
  logic [63:0]   r_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop_cnt;
  // Instruction queue
  logic [31:0]   r_q_data [QUEUE_DEPTH];
  logic [63:0]   r_q_pc   [QUEUE_DEPTH];
  logic [AW-1:0] r_q_rd;
  logic [AW-1:0] r_q_wr;
  logic [CW-1:0] r_q_count;
  // Request PC tags, one per outstanding read
  logic [63:0]   r_tag    [QUEUE_DEPTH];
  logic [AW-1:0] r_tag_rd;
  logic [AW-1:0] r_tag_wr;
  // Registered head of queue presented to decode
  logic [31:0]   r_instruction;
  logic [63:0]   r_inst_pc;

  logic          w_credit;
  logic          w_req_valid;
  logic          w_fire;
  logic          w_resp;
  logic          w_drop;
  logic          w_push;
  logic          w_pop;
  logic [63:0]   w_resp_pc;
  logic [AW-1:0] w_rd_next;
  logic [CW-1:0] w_count_after_pop;
  logic          w_head_load;
  logic [31:0]   w_head_data;
  logic [63:0]   w_head_pc;

  // A request may only issue while every in-flight word is guaranteed a queue slot.
  assign w_credit    = ({1'b0, r_outstanding} + {1'b0, r_q_count}) < (CW + 1)'(QUEUE_DEPTH);
  assign w_req_valid = !reset && !bus.halt && !bus.redirect_valid && w_credit;
  assign w_fire      = w_req_valid && bus.imem_req_ready;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign w_resp      = bus.imem_resp_valid && (r_outstanding != '0);
  assign w_drop      = w_resp && (r_drop_cnt != '0);
  assign w_push      = w_resp && !w_drop && !bus.redirect_valid;
  assign w_pop       = (r_q_count != '0) && bus.inst_ready && !bus.redirect_valid;
  assign w_resp_pc   = r_tag[r_tag_rd];

  assign w_rd_next         = w_pop ? (r_q_rd + PTR_ONE) : r_q_rd;
  assign w_count_after_pop = w_pop ? (r_q_count - CNT_ONE) : r_q_count;

  // Choose what the head registers show after this edge: a word pushed into an
  // otherwise empty queue, or the entry that becomes the head after any pop.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_head_load = 1'b0;
    w_head_data = r_q_data[w_rd_next];
    w_head_pc   = r_q_pc[w_rd_next];
    if (w_push && (w_count_after_pop == '0)) begin
      w_head_load = 1'b1;
      w_head_data = bus.imem_resp_data;
      w_head_pc   = w_resp_pc;
    end else if (w_count_after_pop != '0) begin
      w_head_load = 1'b1;
    end
  end

  // PC, credit counters, pointers, drop counter and head registers; redirect wins.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      r_pc          <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_q_rd        <= '0;
      r_q_wr        <= '0;
      r_q_count     <= '0;
      r_tag_rd      <= '0;
      r_tag_wr      <= '0;
      r_instruction <= '0;
      r_inst_pc     <= '0;
    end else begin
      r_outstanding <= r_outstanding + (w_fire ? CNT_ONE : '0) - (w_resp ? CNT_ONE : '0);
      if (w_fire) begin
        r_pc     <= r_pc + 64'd4;
        r_tag_wr <= r_tag_wr + PTR_ONE;
      end
      if (w_resp) begin
        r_tag_rd <= r_tag_rd + PTR_ONE;
      end
      if (bus.redirect_valid) begin
        r_pc       <= bus.redirect_pc & ~64'h3;
        r_drop_cnt <= r_outstanding - (w_resp ? CNT_ONE : '0);
        r_q_rd     <= r_q_wr;
        r_q_count  <= '0;
      end else begin
        if (w_drop) begin
          r_drop_cnt <= r_drop_cnt - CNT_ONE;
        end
        if (w_push) begin
          r_q_wr <= r_q_wr + PTR_ONE;
        end
        r_q_rd    <= w_rd_next;
        r_q_count <= w_count_after_pop + (w_push ? CNT_ONE : '0);
        if (w_head_load) begin
          r_instruction <= w_head_data;
          r_inst_pc     <= w_head_pc;
        end
      end
    end
  end

  // Tag and queue storage writes.
  always_ff @(posedge clk) begin
    // NOTE: storage arrays are not reset; pointers and counts alone decide which entries are live.
    if (w_fire) begin
      r_tag[r_tag_wr] <= r_pc;
    end
    if (w_push) begin
      r_q_data[r_q_wr] <= bus.imem_resp_data;
      r_q_pc[r_q_wr]   <= w_resp_pc;
    end
  end

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = r_pc;
  assign bus.inst_valid     = (r_q_count != '0);
  assign bus.instruction    = r_instruction;
  assign bus.inst_pc        = r_inst_pc;

endmodule
